bpu_ctrl: RTL and testbench
===========================

# bpu_ctrl

Branch-prediction controller that owns the single access port of the 2-bit-counter pattern history table (PHT). It sits between fetch (prediction lookups) and execute (resolved-branch updates). Each cycle it grants the table to exactly one of the two, forms gshare indices from PC and a speculative global history register (GHR), and buffers resolved updates in a small FIFO. On a mispredict it repairs the GHR and drains pending updates before it serves further lookups.

## Interface
Parameters:
- ADDR_WIDTH, 9, PHT index width (2^ADDR_WIDTH entries)
- GHR_WIDTH, 9, global history length; must be ≤ ADDR_WIDTH
- PC_WIDTH, 64, fetch PC width
- FIFO_DEPTH, 4, update buffer entries; power of two, ≥2

Ports:
- in_Clk  in  1  clock
- in_Rst_N  in  1  asynchronous, active-low reset
- in_lookup_valid  in  1  fetch requests a prediction
- in_lookup_pc  in  PC_WIDTH  branch PC
- out_lookup_ready  out  1  lookup accepted this cycle when high with valid
- out_pred_valid  out  1  registered prediction valid
- out_pred_taken  out  1  predicted direction
- out_pred_idx  out  ADDR_WIDTH  PHT index used, carried with the instruction
- out_pred_ghr  out  GHR_WIDTH  GHR before the shift, carried with the instruction
- in_res_valid  in  1  execute reports a resolved branch
- in_res_idx  in  ADDR_WIDTH  index returned from out_pred_idx
- in_res_ghr  in  GHR_WIDTH  history returned from out_pred_ghr
- in_res_taken  in  1  actual direction
- in_res_mispred  in  1  prediction was wrong
- out_res_ready  out  1  FIFO can accept
- out_pht_addr  out  ADDR_WIDTH  table address, combinational
- out_pht_upd_en  out  1  table updates the counter at out_pht_addr on the next edge
- out_pht_upd_taken  out  1  update direction
- in_pht_pred  in  1  table prediction for out_pht_addr, combinational

## Operation
- Index: idx = in_lookup_pc[ADDR_WIDTH+1:2] XOR zero-extended GHR.
- Lookup accept: in_lookup_valid && out_lookup_ready. out_lookup_ready = (state==RUN) && (count<FIFO_DEPTH).
- Update accept: in_res_valid && out_res_ready. out_res_ready = (count<FIFO_DEPTH). There is no push bypass when full.
- Grant, one per cycle:
  - Update grant when the FIFO is non-empty and (state==RECOVER, or FIFO full, or no lookup valid).
  - Otherwise, lookup grant when a lookup is accepted.
  - Otherwise, idle: out_pht_upd_en=0 and out_pht_addr=0.
- Update grant: out_pht_addr = head idx, out_pht_upd_en=1, out_pht_upd_taken = head taken, FIFO pops.
- Lookup grant: out_pht_addr = idx and out_pht_upd_en=0. On the next edge the controller registers out_pred_valid=1, out_pred_taken=in_pht_pred, out_pred_idx=idx and out_pred_ghr=GHR, and shifts GHR to {GHR[GHR_WIDTH-2:0], in_pht_pred}.
- Mispredict, accepted with in_res_mispred=1:
  - GHR is loaded with {in_res_ghr[GHR_WIDTH-2:0], in_res_taken}. This takes priority over a same-cycle lookup shift; that lookup's prediction is still issued.
  - state goes to RECOVER. The entry itself is pushed normally.
- FSM:
  - RUN → RECOVER on a mispredict accept.
  - RECOVER → RUN on the edge where the FIFO becomes empty with no push in the same cycle.
  - A further mispredict while in RECOVER restores the GHR again and stays in RECOVER.
- FIFO: circular, pointers wrap modulo FIFO_DEPTH. count is tracked separately so full and empty are unambiguous. Simultaneous push and pop leaves count unchanged.

## Timing
- Reset values:
  - out_pred_valid=0, out_pred_taken=0, out_pred_idx=0, out_pred_ghr=0.
  - GHR=0, FIFO empty, state=RUN.
  - Therefore out_lookup_ready=1, out_res_ready=1, out_pht_upd_en=0.
- Prediction latency is 1 cycle from lookup accept. out_pred_valid is a one-cycle pulse per accepted lookup.
- An update pushed at edge N is granted at edge N+1 at the earliest.
- Reset asserted mid-operation clears the FIFO, GHR and FSM immediately. In-flight predictions are dropped.

## Configuration
- BPU_GSHARE_EN defined: indexing as above; GHR is maintained and restored.
- BPU_GSHARE_EN undefined: bimodal mode.
  - idx = in_lookup_pc[ADDR_WIDTH+1:2].
  - GHR is held at 0, and out_pred_ghr=0.
  - Mispredicts still enter RECOVER.

## Structure
- Package bpu_pkg holds:
  - the FSM state type (RUN, RECOVER);
  - the FIFO entry struct (idx, taken);
  - the default width constants.
- One sub-module, bpu_upd_fifo, holds the circular buffer, count, and full/empty outputs. Arbitration, the FSM and the GHR stay in bpu_ctrl.

## Test plan
- Reset, then a lookup at PC 0x1000 with GHR=0 and in_pht_pred=1 → next cycle out_pred_valid=1, taken=1, idx=0x000 (bits [10:2]); GHR becomes 1.
- Lookups held valid every cycle while 4 non-mispredict updates are pushed → FIFO fills, out_lookup_ready drops, one update is granted, ready re-rises; no update is lost.
- Mispredict with in_res_ghr=0x0AA, taken=1 → GHR=0x155; lookups are blocked until 1 queued entry plus the mispredict entry have drained, then the state is RUN.
- Same-cycle lookup accept and mispredict accept → GHR equals the restored value, not the shifted value; the prediction is still issued.
- Idle fetch with 3 queued updates → out_pht_upd_en is high for 3 consecutive cycles with FIFO-order addresses.
- Reset asserted with 2 entries queued in RECOVER → all outputs return to reset values; out_pht_upd_en=0 immediately.

Source files
------------

// File: rtl/bpu_pkg.sv
// =============================================================================
// Module   : bpu_pkg
// Brief    : Shared types and default widths for the branch-prediction controller.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package bpu_pkg;

    localparam int BPU_ADDR_WIDTH = 9;
    localparam int BPU_GHR_WIDTH  = 9;
    localparam int BPU_PC_WIDTH   = 64;
    localparam int BPU_FIFO_DEPTH = 4;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } bpu_state_e;

    typedef struct packed {
        logic [BPU_ADDR_WIDTH-1:0] idx;
        logic                      taken;
    } bpu_entry_t;

endpackage

`default_nettype wire

// File: rtl/bpu_if.sv
// =============================================================================
// Module   : bpu_if
// Brief    : Fetch lookup, prediction, resolved-update and PHT port bundle.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

interface bpu_if
    import bpu_pkg::*;
#(
    parameter int ADDR_WIDTH = BPU_ADDR_WIDTH,
    parameter int GHR_WIDTH  = BPU_GHR_WIDTH,
    parameter int PC_WIDTH   = BPU_PC_WIDTH
);
    logic                  in_lookup_valid;
    logic [PC_WIDTH-1:0]   in_lookup_pc;
    logic                  out_lookup_ready;
    logic                  out_pred_valid;
    logic                  out_pred_taken;
    logic [ADDR_WIDTH-1:0] out_pred_idx;
    logic [GHR_WIDTH-1:0]  out_pred_ghr;
    logic                  in_res_valid;
    logic [ADDR_WIDTH-1:0] in_res_idx;
    logic [GHR_WIDTH-1:0]  in_res_ghr;
    logic                  in_res_taken;
    logic                  in_res_mispred;
    logic                  out_res_ready;
    logic [ADDR_WIDTH-1:0] out_pht_addr;
    logic                  out_pht_upd_en;
    logic                  out_pht_upd_taken;
    logic                  in_pht_pred;

    modport slave (
        input  in_lookup_valid, in_lookup_pc,
        input  in_res_valid, in_res_idx, in_res_ghr, in_res_taken, in_res_mispred,
        input  in_pht_pred,
        output out_lookup_ready, out_pred_valid, out_pred_taken, out_pred_idx, out_pred_ghr,
        output out_res_ready, out_pht_addr, out_pht_upd_en, out_pht_upd_taken
    );

    modport master (
        output in_lookup_valid, in_lookup_pc,
        output in_res_valid, in_res_idx, in_res_ghr, in_res_taken, in_res_mispred,
        output in_pht_pred,
        input  out_lookup_ready, out_pred_valid, out_pred_taken, out_pred_idx, out_pred_ghr,
        input  out_res_ready, out_pht_addr, out_pht_upd_en, out_pht_upd_taken
    );

endinterface

`default_nettype wire

// File: rtl/bpu_upd_fifo.sv
// =============================================================================
// Module   : bpu_upd_fifo
// Brief    : Circular buffer of resolved PHT updates with explicit occupancy count.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module bpu_upd_fifo
    import bpu_pkg::*;
#(
    parameter int  DEPTH   = BPU_FIFO_DEPTH,
    parameter type T_ENTRY = bpu_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  wire logic             in_Clk,
    input  wire logic             in_Rst_N,
    input  wire logic             push_i,
    input  wire T_ENTRY           push_data_i,
    input  wire logic             pop_i,
    output T_ENTRY                head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CNT_W-1:0]      count_o
);

    T_ENTRY             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               w_push, w_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge in_Clk) begin
        if (w_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

`default_nettype wire

// File: rtl/bpu_ctrl.sv
// =============================================================================
// Module   : bpu_ctrl
// Brief    : PHT access arbiter between fetch lookups and buffered resolved
//            updates, with speculative GHR and mispredict recovery.
// Config   : BPU_GSHARE_EN - defined: gshare indexing; undefined: bimodal.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module bpu_ctrl
    import bpu_pkg::*;
#(
    parameter int ADDR_WIDTH = BPU_ADDR_WIDTH,
    parameter int GHR_WIDTH  = BPU_GHR_WIDTH,
    parameter int PC_WIDTH   = BPU_PC_WIDTH,
    parameter int FIFO_DEPTH = BPU_FIFO_DEPTH
) (
    input  wire logic in_Clk,
    input  wire logic in_Rst_N,
    bpu_if.slave      bpu_bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] idx;
        logic                  taken;
    } entry_t;

    bpu_state_e            state_q, state_d;
    logic [GHR_WIDTH-1:0]  ghr_q, ghr_d;
    logic                  pred_valid_q;
    logic                  pred_taken_q;
    logic [ADDR_WIDTH-1:0] pred_idx_q;
    logic [GHR_WIDTH-1:0]  pred_ghr_q;

    entry_t                w_head, w_push_data;
    logic                  w_full, w_empty;
    logic [CNT_W-1:0]      w_count;
    logic [ADDR_WIDTH-1:0] w_lookup_idx;
    logic                  w_lookup_ready, w_res_ready;
    logic                  w_lookup_acc, w_push, w_mispred;
    logic                  w_upd_grant, w_lk_grant, w_drain;

`ifdef BPU_GSHARE_EN
    assign w_lookup_idx = bpu_bus.in_lookup_pc[ADDR_WIDTH+1:2] ^ ADDR_WIDTH'(ghr_q);
    logic w_unused_bits;
    assign w_unused_bits = ^{bpu_bus.in_lookup_pc[PC_WIDTH-1:ADDR_WIDTH+2],
                             bpu_bus.in_lookup_pc[1:0]};
`else
    assign w_lookup_idx = bpu_bus.in_lookup_pc[ADDR_WIDTH+1:2];
    logic w_unused_bits;
    assign w_unused_bits = ^{bpu_bus.in_lookup_pc[PC_WIDTH-1:ADDR_WIDTH+2],
                             bpu_bus.in_lookup_pc[1:0], bpu_bus.in_res_ghr};
`endif

    assign w_res_ready    = !w_full;
    assign w_lookup_ready = (state_q == RUN) && !w_full;
    assign w_lookup_acc   = bpu_bus.in_lookup_valid && w_lookup_ready;
    assign w_push         = bpu_bus.in_res_valid && w_res_ready;
    assign w_mispred      = w_push && bpu_bus.in_res_mispred;

    // Updates win when recovering, when full, or when fetch is quiet.
    assign w_upd_grant = !w_empty &&
                         ((state_q == RECOVER) || w_full || !bpu_bus.in_lookup_valid);
    assign w_lk_grant  = !w_upd_grant && w_lookup_acc;
    assign w_drain     = !w_push &&
                         (w_empty || ((w_count == CNT_W'(1)) && w_upd_grant));

    assign w_push_data.idx   = bpu_bus.in_res_idx;
    assign w_push_data.taken = bpu_bus.in_res_taken;

    bpu_upd_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .T_ENTRY (entry_t)
    ) u_fifo (
        .in_Clk      (in_Clk),
        .in_Rst_N    (in_Rst_N),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_upd_grant),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (w_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (w_mispred) state_d = RECOVER;
            RECOVER: if (!w_mispred && w_drain) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // A restore overrides the shift of a lookup granted in the same cycle.
    always_comb begin
        ghr_d = ghr_q;
`ifdef BPU_GSHARE_EN
        if (w_mispred)
            ghr_d = (bpu_bus.in_res_ghr << 1) | GHR_WIDTH'(bpu_bus.in_res_taken);
        else if (w_lk_grant)
            ghr_d = (ghr_q << 1) | GHR_WIDTH'(bpu_bus.in_pht_pred);
`else
        ghr_d = '0;
`endif
    end

    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            state_q      <= RUN;
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_idx_q   <= '0;
            pred_ghr_q   <= '0;
        end else begin
            state_q      <= state_d;
            ghr_q        <= ghr_d;
            pred_valid_q <= w_lk_grant;
            if (w_lk_grant) begin
                pred_taken_q <= bpu_bus.in_pht_pred;
                pred_idx_q   <= w_lookup_idx;
                pred_ghr_q   <= ghr_q;
            end
        end
    end

    assign bpu_bus.out_lookup_ready  = w_lookup_ready;
    assign bpu_bus.out_res_ready     = w_res_ready;
    assign bpu_bus.out_pred_valid    = pred_valid_q;
    assign bpu_bus.out_pred_taken    = pred_taken_q;
    assign bpu_bus.out_pred_idx      = pred_idx_q;
    assign bpu_bus.out_pred_ghr      = pred_ghr_q;
    assign bpu_bus.out_pht_upd_en    = w_upd_grant;
    assign bpu_bus.out_pht_upd_taken = w_upd_grant && w_head.taken;
    assign bpu_bus.out_pht_addr      = w_upd_grant ? w_head.idx :
                                       w_lk_grant  ? w_lookup_idx : '0;

endmodule

`default_nettype wire

// File: tb/tb_bpu_ctrl.sv
// =============================================================================
// Module   : tb_bpu_ctrl
// Brief    : Scoreboard bench for bpu_ctrl; honours BPU_GSHARE_EN when defined.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_bpu_ctrl;
    import bpu_pkg::*;

    localparam int AW = 9;
    localparam int GW = 9;
    localparam int PW = 64;
`ifdef BPU_GSHARE_EN
    localparam bit GS = 1'b1;
`else
    localparam bit GS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bpu_if #(.ADDR_WIDTH(AW), .GHR_WIDTH(GW), .PC_WIDTH(PW)) bus ();

    bpu_ctrl #(
        .ADDR_WIDTH (AW),
        .GHR_WIDTH  (GW),
        .PC_WIDTH   (PW),
        .FIFO_DEPTH (4)
    ) dut (
        .in_Clk   (clk),
        .in_Rst_N (rst_n),
        .bpu_bus  (bus)
    );

    typedef struct {
        logic          taken;
        logic [AW-1:0] idx;
        logic [GW-1:0] ghr;
    } pred_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          taken;
    } upd_t;

    pred_t         pq[$];
    upd_t          uq[$];
    pred_t         mon_p;
    upd_t          mon_u;
    int            errors = 0;
    int            checks = 0;
    logic [GW-1:0] ghr_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected response whenever the DUT presents one.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_pred_valid) begin
                if (pq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pred_unexpected: got idx %0h expected no prediction", bus.out_pred_idx);
                end else begin
                    mon_p = pq.pop_front();
                    chk("pred_taken", bus.out_pred_taken, mon_p.taken);
                    chk("pred_idx",   bus.out_pred_idx,   mon_p.idx);
                    chk("pred_ghr",   bus.out_pred_ghr,   mon_p.ghr);
                end
            end
            if (bus.out_pht_upd_en) begin
                if (uq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL upd_unexpected: got addr %0h expected no update", bus.out_pht_addr);
                end else begin
                    mon_u = uq.pop_front();
                    chk("upd_addr",  bus.out_pht_addr,      mon_u.addr);
                    chk("upd_taken", bus.out_pht_upd_taken, mon_u.taken);
                end
            end
        end
    end

    task automatic clear_inputs();
        bus.in_lookup_valid = 1'b0;
        bus.in_lookup_pc    = '0;
        bus.in_res_valid    = 1'b0;
        bus.in_res_idx      = '0;
        bus.in_res_ghr      = '0;
        bus.in_res_taken    = 1'b0;
        bus.in_res_mispred  = 1'b0;
        bus.in_pht_pred     = 1'b0;
    endtask

    // One clock of stimulus with the hand-derived ready/grant expectations.
    task automatic cyc(input logic lv, input logic [63:0] pc, input logic pred,
                       input logic rv, input logic [AW-1:0] ridx, input logic [GW-1:0] rghr,
                       input logic rt, input logic rm,
                       input logic e_lr, input logic e_rr, input logic e_upd);
        pred_t p;
        upd_t  u;
        bus.in_lookup_valid = lv;
        bus.in_lookup_pc    = pc;
        bus.in_pht_pred     = pred;
        bus.in_res_valid    = rv;
        bus.in_res_idx      = ridx;
        bus.in_res_ghr      = rghr;
        bus.in_res_taken    = rt;
        bus.in_res_mispred  = rm;
        #1;
        chk("lookup_ready", bus.out_lookup_ready, e_lr);
        chk("res_ready",    bus.out_res_ready,    e_rr);
        chk("pht_upd_en",   bus.out_pht_upd_en,   e_upd);
        if (lv && e_lr) begin
            p.taken = pred;
            p.ghr   = GS ? ghr_m : '0;
            p.idx   = pc[AW+1:2] ^ p.ghr;
            chk("pht_addr_lookup", bus.out_pht_addr, p.idx);
            pq.push_back(p);
            if (GS) ghr_m = {ghr_m[GW-2:0], pred};
        end
        if (rv && e_rr) begin
            u.addr  = ridx;
            u.taken = rt;
            uq.push_back(u);
            if (rm) ghr_m = GS ? {rghr[GW-2:0], rt} : '0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        ghr_m = '0;
        #12;
        chk("rst_pred_valid",  bus.out_pred_valid,   0);
        chk("rst_pred_taken",  bus.out_pred_taken,   0);
        chk("rst_pred_idx",    bus.out_pred_idx,     0);
        chk("rst_pred_ghr",    bus.out_pred_ghr,     0);
        chk("rst_lookup_rdy",  bus.out_lookup_ready, 1);
        chk("rst_res_rdy",     bus.out_res_ready,    1);
        chk("rst_upd_en",      bus.out_pht_upd_en,   0);
        chk("rst_pht_addr",    bus.out_pht_addr,     0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First lookups
        cyc(1, 64'h1000, 1, 0, 9'h000, 9'h000, 0, 0, 1, 1, 0);
        chk("first_pred_idx", bus.out_pred_idx, 0);
        cyc(1, 64'h1004, 0, 0, 9'h000, 9'h000, 0, 0, 1, 1, 0);
        chk("second_pred_ghr", bus.out_pred_ghr, GS ? 9'h001 : 9'h000);

        // Fill the FIFO under continuous lookups
        cyc(1, 64'h2000, 0, 1, 9'h011, 9'h000, 1, 0, 1, 1, 0);
        cyc(1, 64'h2004, 0, 1, 9'h022, 9'h000, 0, 0, 1, 1, 0);
        cyc(1, 64'h2008, 0, 1, 9'h033, 9'h000, 1, 0, 1, 1, 0);
        cyc(1, 64'h200C, 0, 1, 9'h044, 9'h000, 1, 0, 1, 1, 0);
        cyc(1, 64'h2010, 0, 1, 9'h055, 9'h000, 0, 0, 0, 0, 1);
        cyc(1, 64'h2010, 0, 0, 9'h000, 9'h000, 0, 0, 1, 1, 0);

        // Idle fetch drains three queued updates back to back
        for (int i = 0; i < 3; i++)
            cyc(0, 64'h0, 0, 0, 9'h000, 9'h000, 0, 0, 1, 1, 1);
        cyc(0, 64'h0, 0, 0, 9'h000, 9'h000, 0, 0, 1, 1, 0);

        // Push-to-grant latency
        cyc(0, 64'h0, 0, 1, 9'h066, 9'h000, 1, 0, 1, 1, 0);
        cyc(0, 64'h0, 0, 0, 9'h000, 9'h000, 0, 0, 1, 1, 1);

        // Mispredict alongside a lookup, then recovery drain
        cyc(1, 64'h3000, 1, 1, 9'h077, 9'h000, 0, 0, 1, 1, 0);
        cyc(1, 64'h3004, 0, 1, 9'h088, 9'h0AA, 1, 1, 1, 1, 0);
        cyc(1, 64'h3008, 0, 0, 9'h000, 9'h000, 0, 0, 0, 1, 1);
        cyc(1, 64'h3008, 0, 0, 9'h000, 9'h000, 0, 0, 0, 1, 1);
        cyc(1, 64'h3008, 1, 0, 9'h000, 9'h000, 0, 0, 1, 1, 0);
        chk("recover_ghr", bus.out_pred_ghr, GS ? 9'h155 : 9'h000);
        chk("recover_idx", bus.out_pred_idx, GS ? 9'h157 : 9'h002);

        // Reset while recovering with two entries queued
        cyc(1, 64'h4000, 0, 1, 9'h099, 9'h000, 1, 0, 1, 1, 0);
        cyc(1, 64'h4004, 1, 1, 9'h0AB, 9'h001, 0, 1, 1, 1, 0);
        clear_inputs();
        #1;
        chk("pre_rst_upd_en",     bus.out_pht_upd_en,   1);
        chk("pre_rst_lookup_rdy", bus.out_lookup_ready, 0);
        chk("pre_rst_pred_valid", bus.out_pred_valid,   1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pred_valid", bus.out_pred_valid,   0);
        chk("mid_rst_pred_taken", bus.out_pred_taken,   0);
        chk("mid_rst_pred_idx",   bus.out_pred_idx,     0);
        chk("mid_rst_pred_ghr",   bus.out_pred_ghr,     0);
        chk("mid_rst_lookup_rdy", bus.out_lookup_ready, 1);
        chk("mid_rst_res_rdy",    bus.out_res_ready,    1);
        chk("mid_rst_upd_en",     bus.out_pht_upd_en,   0);
        chk("mid_rst_pht_addr",   bus.out_pht_addr,     0);
        pq.delete();
        uq.delete();
        ghr_m = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cyc(1, 64'h1008, 1, 0, 9'h000, 9'h000, 0, 0, 1, 1, 0);
        chk("post_rst_idx", bus.out_pred_idx, 9'h002);
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("pred_queue_drained", pq.size(), 0);
        chk("upd_queue_drained",  uq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
